axi_burst_master: RTL and testbench

Command-driven AXI master that issues one INCR burst (read or write) at a time on an `axi_channel.master` port. Accepts a request, streams write data in or read data out through valid/ready ports, and returns the burst's final response. It connects simple DMA engines, test sequencers and bridge front-ends to an AXI interconnect.

---
 rtl/axi_common.sv | 23 ++
 rtl/axi_channel.sv | 88 ++++++++
 rtl/axi_burst_master.sv | 203 ++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_common.sv
// Shared AXI types and constants.
// Response codes, burst kinds and the beat-size helper.
package axi_common;

  typedef logic [1:0] resp_t;
  typedef logic [1:0] burst_t;
  typedef logic [2:0] size_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;
  localparam burst_t BURST_WRAP  = 2'b10;

  // AXI size encoding for a full-width beat
  function automatic size_t axi_size(input int unsigned data_width);
    return size_t'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axi_channel.sv
// AXI4 channel bundle with master/slave views.
// Parameters must match the blocks attached to it.
interface axi_channel
  import axi_common::*;
#(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 8
) (
  input logic clk,
  input logic rstn
);

  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  size_t                   aw_size;
  burst_t                  aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic                    w_valid;
  logic                    w_ready;

  logic [ID_WIDTH-1:0]     b_id;
  resp_t                   b_resp;
  logic                    b_valid;
  logic                    b_ready;

  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  size_t                   ar_size;
  burst_t                  ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  resp_t                   r_resp;
  logic                    r_last;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    input  clk, rstn,
    output aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output aw_lock, aw_cache, aw_prot, aw_qos, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output ar_lock, ar_cache, ar_prot, ar_qos, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready
  );

  modport slave (
    input  clk, rstn,
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input  aw_lock, aw_cache, aw_prot, aw_qos, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_lock, ar_cache, ar_prot, ar_qos, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI INCR burst master.
// One command in, one burst on the bus, one response out.
module axi_burst_master
  import axi_common::*;
#(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [7:0]              req_len,
  input  logic [ID_WIDTH-1:0]     req_id,
  input  logic                    wdata_valid,
  output logic                    wdata_ready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    rdata_valid,
  input  logic                    rdata_ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rdata_last,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output resp_t                   resp,
  axi_channel.master              master
);

  if ($bits(master.aw_addr) != ADDR_WIDTH) begin : g_bad_aw
    $fatal(1, "axi_burst_master: ADDR_WIDTH mismatch");
  end
  if ($bits(master.w_data) != DATA_WIDTH) begin : g_bad_dw
    $fatal(1, "axi_burst_master: DATA_WIDTH mismatch");
  end
  if ($bits(master.aw_id) != ID_WIDTH) begin : g_bad_iw
    $fatal(1, "axi_burst_master: ID_WIDTH mismatch");
  end
  if (DATA_WIDTH < 8 ||
      (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_pow
    $fatal(1, "axi_burst_master: DATA_WIDTH not pow2 >= 8");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_t;

  localparam size_t BEAT_SIZE = axi_size(DATA_WIDTH);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]            cnt_q, cnt_d;
  resp_t                 resp_q, resp_d;
  logic                  last_beat;
  logic                  aw_valid, w_valid, b_ready;
  logic                  ar_valid, r_ready;

  function automatic resp_t merge(input resp_t cur,
                                  input resp_t nxt);
    return (cur == RESP_OKAY) ? nxt : cur;
  endfunction

  function automatic logic [7:0] step(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign last_beat = (cnt_q == len_q);

  // Next-state, burst context and handshake decode
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    resp_d      = resp_q;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    rdata_valid = 1'b0;
    rdata_last  = 1'b0;
    resp_valid  = 1'b0;
    aw_valid    = 1'b0;
    w_valid     = 1'b0;
    b_ready     = 1'b0;
    ar_valid    = 1'b0;
    r_ready     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          len_d   = req_len;
          id_d    = req_id;
          cnt_d   = '0;
          resp_d  = RESP_OKAY;
          state_d = req_write ? S_AW : S_AR;
        end
      end
      S_AW: begin
        aw_valid = 1'b1;
        if (master.aw_ready) state_d = S_W;
      end
      S_W: begin
        w_valid     = wdata_valid;
        wdata_ready = master.w_ready;
        if (wdata_valid && master.w_ready) begin
          cnt_d = step(cnt_q);
          if (last_beat) state_d = S_B;
        end
      end
      S_B: begin
        b_ready = 1'b1;
        if (master.b_valid) begin
          resp_d  = merge(resp_q, master.b_resp);
          state_d = S_DONE;
        end
      end
      S_AR: begin
        ar_valid = 1'b1;
        if (master.ar_ready) state_d = S_R;
      end
      S_R: begin
        rdata_valid = master.r_valid;
        rdata_last  = master.r_last;
        r_ready     = rdata_ready;
        if (master.r_valid && rdata_ready) begin
          cnt_d = step(cnt_q);
          // a misplaced or missing r_last overrides the beat response
          if (master.r_last != last_beat)
            resp_d = RESP_SLVERR;
          else
            resp_d = merge(resp_q, master.r_resp);
          if (master.r_last) state_d = S_DONE;
        end
      end
      S_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Latched request, beat counter and sticky response
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      len_q  <= '0;
      id_q   <= '0;
      cnt_q  <= '0;
      resp_q <= RESP_OKAY;
    end else begin
      addr_q <= addr_d;
      len_q  <= len_d;
      id_q   <= id_d;
      cnt_q  <= cnt_d;
      resp_q <= resp_d;
    end
  end

  assign resp            = resp_q;
  assign rdata           = master.r_data;

  assign master.aw_id    = id_q;
  assign master.aw_addr  = addr_q;
  assign master.aw_len   = len_q;
  assign master.aw_size  = BEAT_SIZE;
  assign master.aw_burst = BURST_INCR;
  assign master.aw_lock  = 1'b0;
  assign master.aw_cache = '0;
  assign master.aw_prot  = '0;
  assign master.aw_qos   = '0;
  assign master.aw_valid = aw_valid;

  assign master.w_data   = wdata;
  assign master.w_strb   = wstrb;
  assign master.w_last   = last_beat;
  assign master.w_valid  = w_valid;
  assign master.b_ready  = b_ready;

  assign master.ar_id    = id_q;
  assign master.ar_addr  = addr_q;
  assign master.ar_len   = len_q;
  assign master.ar_size  = BEAT_SIZE;
  assign master.ar_burst = BURST_INCR;
  assign master.ar_lock  = 1'b0;
  assign master.ar_cache = '0;
  assign master.ar_prot  = '0;
  assign master.ar_qos   = '0;
  assign master.ar_valid = ar_valid;
  assign master.r_ready  = r_ready;

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master.
// Randomised AXI slave plus burst-level reference model.
module tb_axi_burst_master;
  import axi_common::*;

  localparam int AW = 48;
  localparam int DW = 64;
  localparam int IW = 8;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_len;
  logic [IW-1:0] req_id;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          rdata_valid, rdata_ready, rdata_last;
  logic [DW-1:0] rdata;
  logic          resp_valid, resp_ready;
  resp_t         resp;

  axi_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW))
    bus (.clk(clk), .rstn(~rst));

  axi_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_len(req_len), .req_id(req_id),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .wdata(wdata), .wstrb(wstrb),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
    .rdata(rdata), .rdata_last(rdata_last),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp(resp), .master(bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus tables
  logic [DW-1:0] wr_data [256];
  logic [SW-1:0] wr_strb [256];
  logic [DW-1:0] rd_data [256];
  resp_t         rd_resp [256];
  int            rd_last_at;
  resp_t         b_resp_val;
  int            stall = 0;
  int            rst_after_w = -1;

  // observations of one burst
  logic [AW-1:0] got_addr;
  logic [IW-1:0] got_id;
  logic [7:0]    got_len;
  size_t         got_size;
  burst_t        got_burst;
  logic [11:0]   got_side;
  bit            got_a_wr;
  logic [DW-1:0] w_q [$];
  logic [SW-1:0] ws_q [$];
  bit            wl_q [$];
  logic [DW-1:0] r_q [$];
  bit            rl_q [$];
  resp_t         got_resp;
  int t_req, t_a_first, t_resp_first, t_resp, t_rdy;
  bit            timed_out;
  int            stab_err;

  function automatic bit go();
    return $urandom_range(99) >= stall;
  endfunction

  task automatic drive_idle();
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = '0;
    req_len      = '0;
    req_id       = '0;
    wdata_valid  = 1'b0;
    wdata        = '0;
    wstrb        = '0;
    rdata_ready  = 1'b0;
    resp_ready   = 1'b0;
    bus.aw_ready = 1'b0;
    bus.w_ready  = 1'b0;
    bus.b_valid  = 1'b0;
    bus.b_resp   = RESP_OKAY;
    bus.b_id     = '0;
    bus.ar_ready = 1'b0;
    bus.r_valid  = 1'b0;
    bus.r_data   = '0;
    bus.r_resp   = RESP_OKAY;
    bus.r_last   = 1'b0;
    bus.r_id     = '0;
  endtask

  task automatic fill(input int l);
    for (int i = 0; i < 256; i++) begin
      wr_data[i] = {$urandom, $urandom};
      wr_strb[i] = 8'($urandom);
      rd_data[i] = {$urandom, $urandom};
      rd_resp[i] = RESP_OKAY;
    end
    rd_last_at = l;
    b_resp_val = RESP_OKAY;
  endtask

  // reference: first non-OKAY beat wins, a misplaced r_last gives SLVERR
  function automatic resp_t model_read(input int l);
    if (rd_last_at != l) return RESP_SLVERR;
    for (int i = 0; i <= rd_last_at; i++)
      if (rd_resp[i] != RESP_OKAY) return rd_resp[i];
    return RESP_OKAY;
  endfunction

  // drives one burst through the DUT and records what happened
  task automatic do_burst(input bit wr, input logic [AW-1:0] a,
                          input logic [7:0] l,
                          input logic [IW-1:0] id);
    int src = 0, sr = 0, n = 0;
    bit req_done = 0, a_done = 0, b_pend = 0, r_end = 0;
    bit rv_pend = 0, a_pend = 0, rs_pend = 0, done = 0;
    bit hs;
    logic [AW-1:0] ca, a_prev;
    logic [IW-1:0] ci, i_prev;
    resp_t rs_prev;
    w_q.delete(); ws_q.delete(); wl_q.delete();
    r_q.delete(); rl_q.delete();
    got_addr = '0; got_id = '0; got_len = '0; got_size = '0;
    got_burst = '0; got_side = '0; got_a_wr = 0;
    got_resp = RESP_OKAY;
    t_req = -1; t_a_first = -1; t_resp_first = -1;
    t_resp = -1; t_rdy = -1;
    timed_out = 0; stab_err = 0;
    a_prev = '0; i_prev = '0; rs_prev = RESP_OKAY;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
      req_valid    = !req_done;
      req_write    = wr;
      req_addr     = a;
      req_len      = l;
      req_id       = id;
      wdata_valid  = wr && req_done && src <= int'(l) && go();
      wdata        = wr_data[src % 256];
      wstrb        = wr_strb[src % 256];
      bus.aw_ready = go();
      bus.w_ready  = go();
      bus.b_valid  = b_pend;
      bus.b_resp   = b_resp_val;
      bus.b_id     = id;
      bus.ar_ready = go();
      if (!rv_pend)
        bus.r_valid = !wr && a_done && !r_end && go();
      bus.r_data   = rd_data[sr % 256];
      bus.r_resp   = rd_resp[sr % 256];
      bus.r_last   = (sr == rd_last_at);
      bus.r_id     = id;
      rdata_ready  = go();
      resp_ready   = go();
      #1;
      if (req_valid && req_ready) begin
        req_done = 1;
        t_req = cyc;
      end
      if (bus.aw_valid || bus.ar_valid) begin
        if (t_a_first < 0) t_a_first = cyc;
        got_a_wr = bus.aw_valid;
        ca = bus.aw_valid ? bus.aw_addr : bus.ar_addr;
        ci = bus.aw_valid ? bus.aw_id : bus.ar_id;
        if (a_pend && (ca !== a_prev || ci !== i_prev))
          stab_err++;
        if (bus.aw_valid) begin
          got_len = bus.aw_len; got_size = bus.aw_size;
          got_burst = bus.aw_burst;
          got_side = {bus.aw_lock, bus.aw_cache,
                      bus.aw_prot, bus.aw_qos};
        end else begin
          got_len = bus.ar_len; got_size = bus.ar_size;
          got_burst = bus.ar_burst;
          got_side = {bus.ar_lock, bus.ar_cache,
                      bus.ar_prot, bus.ar_qos};
        end
        got_addr = ca;
        got_id = ci;
        hs = bus.aw_valid ? bus.aw_ready : bus.ar_ready;
        if (hs) begin
          a_done = 1; a_pend = 0;
        end else begin
          a_pend = 1; a_prev = ca; i_prev = ci;
        end
      end else if (a_pend) stab_err++;
      if (wdata_valid && wdata_ready) src++;
      if (bus.w_valid && bus.w_ready) begin
        w_q.push_back(bus.w_data);
        ws_q.push_back(bus.w_strb);
        wl_q.push_back(bus.w_last);
        if (bus.w_last) b_pend = 1;
      end
      if (bus.b_valid && bus.b_ready) b_pend = 0;
      if (bus.r_valid && bus.r_ready) begin
        if (bus.r_last) r_end = 1;
        sr++;
      end
      rv_pend = bus.r_valid && !bus.r_ready;
      if (rdata_valid && rdata_ready) begin
        r_q.push_back(rdata);
        rl_q.push_back(rdata_last);
      end
      if (resp_valid) begin
        if (t_resp_first < 0) t_resp_first = cyc;
        if (rs_pend && resp !== rs_prev) stab_err++;
        if (resp_ready) begin
          got_resp = resp; t_resp = cyc;
          done = 1; rs_pend = 0;
        end else begin
          rs_pend = 1; rs_prev = resp;
        end
      end else if (rs_pend) stab_err++;
      if (rst_after_w >= 0 && int'(w_q.size()) >= rst_after_w)
        done = 1;
    end
    if (!done) timed_out = 1;
    @(negedge clk);
    drive_idle();
    #1;
    if (req_ready) t_rdy = cyc;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    v = {bus.aw_valid, bus.ar_valid, bus.w_valid, bus.b_ready,
         bus.r_ready, wdata_ready, rdata_valid, resp_valid};
    n_tests++;
    if (v !== 8'h00) begin
      n_fail++; $display("FAIL reset_valids: got %b want 0", v);
    end
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: got %b want 1",
                         req_ready);
    end
    n_tests++;
    if (resp !== RESP_OKAY) begin
      n_fail++; $display("FAIL reset_resp: got %0d want 0", resp);
    end
    n_tests++;
    if (bus.aw_addr !== '0 || bus.aw_len !== '0 ||
        bus.aw_id !== '0) begin
      n_fail++; $display("FAIL reset_fields: addr %0h len %0d id %0d want 0",
                         bus.aw_addr, bus.aw_len, bus.aw_id);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_len3();
    int bad = 0;
    stall = 0;
    fill(3);
    do_burst(1'b1, 48'h1000, 8'd3, 8'd5);
    n_tests++;
    if (timed_out) begin
      n_fail++; $display("FAIL w3_timeout: got 1 want 0");
    end
    n_tests++;
    if (!got_a_wr || got_addr !== 48'h1000 || got_len !== 8'd3 ||
        got_size !== 3'd3 || got_burst !== BURST_INCR ||
        got_id !== 8'd5 || got_side !== '0) begin
      n_fail++;
      $display("FAIL w3_aw: aw %b addr %0h len %0d size %0d burst %0d id %0d side %0h",
               got_a_wr, got_addr, got_len, got_size, got_burst,
               got_id, got_side);
    end
    n_tests++;
    if (w_q.size() != 4) begin
      n_fail++; $display("FAIL w3_beats: got %0d want 4", w_q.size());
    end
    for (int i = 0; i < w_q.size() && i < 4; i++)
      if (w_q[i] !== wr_data[i] || ws_q[i] !== wr_strb[i] ||
          wl_q[i] !== (i == 3)) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL w3_data: got %0d bad beats want 0", bad);
    end
    n_tests++;
    if (t_a_first - t_req != 1 || t_resp_first - t_req != 7) begin
      n_fail++; $display("FAIL w3_timing: aw +%0d resp +%0d want +1 +7",
                         t_a_first - t_req, t_resp_first - t_req);
    end
    n_tests++;
    if (got_resp !== RESP_OKAY) begin
      n_fail++; $display("FAIL w3_resp: got %0d want 0", got_resp);
    end
  endtask

  task automatic test_read_len0();
    stall = 0;
    fill(0);
    rd_data[0] = 64'hDEADBEEF;
    do_burst(1'b0, 48'h0000_2345_6780, 8'd0, 8'd3);
    n_tests++;
    if (got_a_wr || got_addr !== 48'h0000_2345_6780 ||
        got_len !== 8'd0 || got_id !== 8'd3 ||
        got_burst !== BURST_INCR) begin
      n_fail++; $display("FAIL r0_ar: aw %b addr %0h len %0d id %0d",
                         got_a_wr, got_addr, got_len, got_id);
    end
    n_tests++;
    if (r_q.size() != 1 || r_q[0] !== 64'hDEADBEEF ||
        rl_q[0] !== 1'b1) begin
      n_fail++; $display("FAIL r0_beat: n %0d data %0h last %b want 1 deadbeef 1",
                         r_q.size(), r_q[0], rl_q[0]);
    end
    n_tests++;
    if (got_resp !== RESP_OKAY || timed_out) begin
      n_fail++; $display("FAIL r0_resp: got %0d to %b want 0",
                         got_resp, timed_out);
    end
    n_tests++;
    if (t_rdy - t_req != 4) begin
      n_fail++; $display("FAIL r0_latency: got +%0d want +4",
                         t_rdy - t_req);
    end
  endtask

  task automatic test_read_errs();
    stall = 0;
    fill(2);
    rd_resp[1] = RESP_SLVERR;
    rd_resp[2] = RESP_DECERR;
    do_burst(1'b0, 48'h40, 8'd2, 8'd9);
    n_tests++;
    if (r_q.size() != 3) begin
      n_fail++; $display("FAIL rerr_beats: got %0d want 3", r_q.size());
    end
    n_tests++;
    if (got_resp !== RESP_SLVERR) begin
      n_fail++; $display("FAIL rerr_sticky: got %0d want 2", got_resp);
    end
  endtask

  task automatic test_early_rlast();
    stall = 0;
    fill(3);
    rd_last_at = 1;
    do_burst(1'b0, 48'h80, 8'd3, 8'd1);
    n_tests++;
    if (timed_out || r_q.size() != 2) begin
      n_fail++; $display("FAIL early_beats: got %0d to %b want 2",
                         r_q.size(), timed_out);
    end
    n_tests++;
    if (rl_q[0] !== 1'b0 || rl_q[1] !== 1'b1 ||
        r_q[1] !== rd_data[1]) begin
      n_fail++; $display("FAIL early_last: got %b%b want 01",
                         rl_q[0], rl_q[1]);
    end
    n_tests++;
    if (got_resp !== RESP_SLVERR) begin
      n_fail++; $display("FAIL early_resp: got %0d want 2", got_resp);
    end
  endtask

  task automatic test_random_stalls();
    bit            wr;
    int            l, nb, bad;
    logic [AW-1:0] a;
    logic [IW-1:0] id;
    resp_t         exp;
    stall = 40;
    for (int it = 0; it < 24; it++) begin
      wr = (it < 2) ? (it == 0) : 1'($urandom);
      l  = (it < 2) ? 255 : $urandom_range(15);
      a  = {$urandom, $urandom};
      id = 8'($urandom);
      fill(l);
      b_resp_val = 2'($urandom);
      for (int i = 0; i < 256; i++)
        if ($urandom_range(3) == 0) rd_resp[i] = 2'($urandom);
      if (!wr && l > 0 && $urandom_range(3) == 0)
        rd_last_at = $urandom_range(l - 1);
      do_burst(wr, a, 8'(l), id);
      nb  = wr ? l + 1 : rd_last_at + 1;
      exp = wr ? b_resp_val : model_read(l);
      bad = 0;
      for (int i = 0; i < nb; i++) begin
        if (wr) begin
          if (i >= w_q.size() || w_q[i] !== wr_data[i] ||
              ws_q[i] !== wr_strb[i] || wl_q[i] !== (i == l))
            bad++;
        end else begin
          if (i >= r_q.size() || r_q[i] !== rd_data[i] ||
              rl_q[i] !== (i == nb - 1))
            bad++;
        end
      end
      n_tests++;
      if (timed_out || got_a_wr != wr || got_addr !== a ||
          got_len !== 8'(l) || got_id !== id) begin
        n_fail++; $display("FAIL rnd%0d_addr: to %b wr %b addr %0h len %0d id %0d",
                           it, timed_out, got_a_wr, got_addr,
                           got_len, got_id);
      end
      n_tests++;
      if ((wr ? w_q.size() : r_q.size()) != nb || bad != 0) begin
        n_fail++; $display("FAIL rnd%0d_beats: got %0d (%0d bad) want %0d",
                           it, wr ? w_q.size() : r_q.size(), bad, nb);
      end
      n_tests++;
      if (got_resp !== exp) begin
        n_fail++; $display("FAIL rnd%0d_resp: got %0d want %0d",
                           it, got_resp, exp);
      end
      n_tests++;
      if (stab_err != 0) begin
        n_fail++; $display("FAIL rnd%0d_stable: got %0d want 0",
                           it, stab_err);
      end
    end
    stall = 0;
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] v;
    stall = 0;
    fill(3);
    rst_after_w = 2;
    do_burst(1'b1, 48'h3000, 8'd3, 8'd7);
    rst_after_w = -1;
    n_tests++;
    if (w_q.size() != 2) begin
      n_fail++; $display("FAIL mid_pre: got %0d beats want 2", w_q.size());
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    v = {bus.aw_valid, bus.ar_valid, bus.w_valid, bus.b_ready,
         bus.r_ready, wdata_ready, rdata_valid, resp_valid};
    n_tests++;
    if (v !== 8'h00 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset: valids %b rdy %b want 0 1",
                         v, req_ready);
    end
    rst = 1'b0;
    fill(3);
    b_resp_val = RESP_EXOKAY;
    do_burst(1'b1, 48'h5000, 8'd3, 8'd2);
    n_tests++;
    if (timed_out || w_q.size() != 4 || wl_q[3] !== 1'b1 ||
        w_q[0] !== wr_data[0] || w_q[3] !== wr_data[3]) begin
      n_fail++; $display("FAIL mid_fresh_beats: got %0d to %b want 4",
                         w_q.size(), timed_out);
    end
    n_tests++;
    if (got_resp !== RESP_EXOKAY ||
        t_resp_first - t_req != 7) begin
      n_fail++; $display("FAIL mid_fresh_resp: got %0d at +%0d want 1 at +7",
                         got_resp, t_resp_first - t_req);
    end
  endtask

  initial begin
    test_reset();
    test_write_len3();
    test_read_len0();
    test_read_errs();
    test_early_rlast();
    test_random_stalls();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
